// File: rtl/nn_pkg.sv
// Shared definitions for the two-layer network datapath.
// Holds the Q8.8 score format, the class-count default and the small
// enumerations used by the output classifier. The M2/gSRAM path and
// the Sigmoid stage import the same package so all stages agree on
// the score format.
package nn_pkg;

   // Q8.8 signed fixed point: 8 integer bits, 8 fractional bits
   localparam int DATA_W    = 16;
   localparam int FRAC_W    = 8;

   // Default network shape
   localparam int N_CLASSES = 10;
   localparam int IDX_W     = 4;

   // Most negative representable score, used to seed the runner-up
   localparam logic signed [DATA_W-1:0] SCORE_MIN = 16'sh8000;

   typedef logic signed [DATA_W-1:0] score_t;
   typedef logic [IDX_W-1:0]         class_idx_t;

   // ACCUM collects a frame of scores, HOLD presents the result
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } cls_state_t;

endpackage

// File: rtl/output_classifier_top2_tracker.sv
// top2_tracker: combinational top-2 update for one incoming score.
// Given the running maximum, runner-up and winning index, plus the new
// score and its index, produces the updated trio. The first flag marks
// index 0, which restarts the trackers for a new frame.
//
// Ports:
//   cur_max, cur_second  running max / runner-up (signed)
//   cur_cls              index of the running max
//   new_score, new_idx   score being accepted and its class index
//   first                high when new_score is the first of a frame
//   nxt_max, nxt_second, nxt_cls   updated tracker values
module top2_tracker
   import nn_pkg::*;
#(
   parameter int DW = nn_pkg::DATA_W,
   parameter int IW = nn_pkg::IDX_W
) (
   input  logic signed [DW-1:0] cur_max,
   input  logic signed [DW-1:0] cur_second,
   input  logic [IW-1:0]        cur_cls,
   input  logic signed [DW-1:0] new_score,
   input  logic [IW-1:0]        new_idx,
   input  logic                 first,
   output logic signed [DW-1:0] nxt_max,
   output logic signed [DW-1:0] nxt_second,
   output logic [IW-1:0]        nxt_cls
);

   localparam logic signed [DW-1:0] SEED_MIN = {1'b1, {(DW-1){1'b0}}};

   // Strict greater-than on the max keeps the lowest index on ties;
   // an equal score still falls through to the runner-up compare, so
   // a tie produces a zero margin.
   always_comb begin
      nxt_max    = cur_max;
      nxt_second = cur_second;
      nxt_cls    = cur_cls;
      if (first) begin
         nxt_max    = new_score;
         nxt_second = SEED_MIN;
         nxt_cls    = '0;
      end else if (new_score > cur_max) begin
         nxt_second = cur_max;
         nxt_max    = new_score;
         nxt_cls    = new_idx;
      end else if (new_score > cur_second) begin
         nxt_second = new_score;
      end
   end

endmodule

// File: rtl/output_classifier.sv
// output_classifier: picks the winning class of each frame of scores.
// Accepts N_CLASSES signed Q8.8 scores per frame over a valid/ready
// input, tracks the top two, and presents class index, max score and
// the max-minus-runner-up margin over a valid/ready output. The input
// stalls while a result is waiting to be taken.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   clear              synchronous abort of partial frame / pending result
//   in_valid, in_ready, in_score       score input handshake
//   out_valid, out_ready               result output handshake
//   out_class, out_score, out_margin   result registers
module output_classifier
   import nn_pkg::*;
#(
   parameter int N_CLASSES = nn_pkg::N_CLASSES,
   parameter int DATA_W    = nn_pkg::DATA_W,
   parameter int IDX_W     = nn_pkg::IDX_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_score,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [IDX_W-1:0]     out_class,
   output logic [DATA_W-1:0]    out_score,
   output logic [DATA_W-1:0]    out_margin
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

   cls_state_t                state;
   logic [IDX_W-1:0]          idx;
   logic signed [DATA_W-1:0]  max_r;
   logic signed [DATA_W-1:0]  second_r;
   logic [IDX_W-1:0]          cls_r;

   logic signed [DATA_W-1:0]  nxt_max;
   logic signed [DATA_W-1:0]  nxt_second;
   logic [IDX_W-1:0]          nxt_cls;
   logic [DATA_W-1:0]         margin;
   logic                      accept;

   // Handshake flags come straight from the state register, so in_ready
   // never depends on in_valid.
   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;

   top2_tracker #(
      .DW (DATA_W),
      .IW (IDX_W)
   ) u_tracker (
      .cur_max    (max_r),
      .cur_second (second_r),
      .cur_cls    (cls_r),
      .new_score  ($signed(in_score)),
      .new_idx    (idx),
      .first      (idx == '0),
      .nxt_max    (nxt_max),
      .nxt_second (nxt_second),
      .nxt_cls    (nxt_cls)
   );

   // The true margin lies in 0..2^DATA_W-1, so the modular DATA_W-bit
   // difference equals the low bits of the exact wide subtraction.
   // With a single class the runner-up is still the seed minimum, which
   // yields max + 2^(DATA_W-1) without a special case.
   assign margin = nxt_max - nxt_second;

   // Frame sequencing: trackers update on every accepted score, results
   // load on the last one, and clear overrides any same-cycle handshake
   // while leaving the result registers untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ACCUM;
         idx        <= '0;
         max_r      <= '0;
         second_r   <= '0;
         cls_r      <= '0;
         out_class  <= '0;
         out_score  <= '0;
         out_margin <= '0;
      end else if (clear) begin
         state <= ACCUM;
         idx   <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  max_r    <= nxt_max;
                  second_r <= nxt_second;
                  cls_r    <= nxt_cls;
                  if (idx == LAST_IDX) begin
                     state      <= HOLD;
                     idx        <= '0;
                     out_class  <= nxt_cls;
                     out_score  <= nxt_max;
                     out_margin <= margin;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state <= ACCUM;
               end
            end
            default: begin
               state <= ACCUM;
            end
         endcase
      end
   end

endmodule
